// File: rtl/intersection_scheduler.sv
// Two-axis intersection phase scheduler: green/yellow/left/yellow/all-red per axis, pedestrian walk
// for the stopped axis, emergency preemption. Define PED_DEMAND_EN to grant walk only on request.
module intersection_scheduler #(
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_YELLOW = 2,
    parameter int unsigned T_LEFT   = 10,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_WALK   = 14,
    parameter int unsigned T_FLASH  = 6,
    parameter int unsigned CW       = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic [3:0] i_ped_req,
    input  logic       i_emg_req,
    input  logic       i_emg_axis,
    output logic [3:0] o_e_ct,
    output logic [3:0] o_w_ct,
    output logic [3:0] o_s_ct,
    output logic [3:0] o_n_ct,
    output logic [1:0] o_e_wt,
    output logic [1:0] o_w_wt,
    output logic [1:0] o_s_wt,
    output logic [1:0] o_n_wt,
    output logic       o_axis,
    output logic [3:0] o_ped_pending
);

    typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YEL1, S_LEFT, S_YEL2, S_ALLRED} state_t;

    localparam logic [3:0] CT_GREEN  = 4'b0001;
    localparam logic [3:0] CT_LEFT   = 4'b0010;
    localparam logic [3:0] CT_YELLOW = 4'b0100;
    localparam logic [3:0] CT_RED    = 4'b1000;
    localparam logic [1:0] WT_GREEN  = 2'b01;
    localparam logic [1:0] WT_RED    = 2'b10;
    localparam logic [1:0] WT_DARK   = 2'b00;
    localparam logic [CW-1:0] WALK_STEADY = CW'(T_WALK - T_FLASH);
    localparam logic [CW-1:0] WALK_END    = CW'(T_WALK);

    state_t          r_state;
    logic            r_axis;
    logic [CW-1:0]   r_cnt;
    logic            r_walk;
    logic [3:0]      r_pend;

    logic [CW-1:0]   phase_last;
    logic            phase_end;
    logic            emg_other;
    logic            emg_same;
    logic            enter_green;
    logic            next_axis;
    logic [3:0]      stop_mask;
    logic            grant;
    logic [3:0]      ped_clear;

    // Last count value of the current phase
    always_comb begin
        phase_last = '0;
        case (r_state)
            S_GREEN:        phase_last = CW'(T_GREEN - 1);
            S_YEL1, S_YEL2: phase_last = CW'(T_YELLOW - 1);
            S_LEFT:         phase_last = CW'(T_LEFT - 1);
            S_ALLRED:       phase_last = CW'(T_ALLRED - 1);
            default:        phase_last = '0;
        endcase
    end

    assign phase_end = (r_cnt == phase_last);
    assign emg_other = i_emg_req && (i_emg_axis != r_axis);
    assign emg_same  = i_emg_req && (i_emg_axis == r_axis);

    // GREEN entry happens from IDLE on start, or at the end of ALLRED
    always_comb begin
        enter_green = 1'b0;
        next_axis   = r_axis;
        if (i_start) begin
            if (r_state == S_IDLE) begin
                enter_green = 1'b1;
                next_axis   = 1'b0;
            end else if (i_tick && r_state == S_ALLRED && phase_end) begin
                enter_green = 1'b1;
                next_axis   = emg_same ? r_axis : ~r_axis;
            end
        end
    end

    assign stop_mask = next_axis ? 4'b0011 : 4'b1100;
`ifdef PED_DEMAND_EN
    assign grant = |(r_pend & stop_mask);
`else
    assign grant = 1'b1;
`endif
    assign ped_clear = (enter_green && grant) ? stop_mask : 4'b0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_axis  <= 1'b0;
            r_walk  <= 1'b0;
            r_pend  <= 4'b0000;
        end else begin
            r_pend <= (r_pend | i_ped_req) & ~ped_clear;
            if (!i_start) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_axis  <= 1'b0;
                r_walk  <= 1'b0;
            end else if (enter_green) begin
                r_state <= S_GREEN;
                r_cnt   <= '0;
                r_axis  <= next_axis;
                r_walk  <= grant;
            end else if (i_tick) begin
                case (r_state)
                    S_GREEN, S_YEL1, S_LEFT: begin
                        if (emg_other) begin
                            r_state <= S_YEL2;
                            r_cnt   <= '0;
                        end else if (r_state == S_GREEN && emg_same) begin
                            r_cnt <= r_cnt;
                        end else if (phase_end) begin
                            r_cnt <= '0;
                            if (r_state == S_GREEN)     r_state <= S_YEL1;
                            else if (r_state == S_YEL1) r_state <= S_LEFT;
                            else                        r_state <= S_YEL2;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_YEL2: begin
                        if (phase_end) begin
                            r_state <= S_ALLRED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_ALLRED: r_cnt <= r_cnt + CW'(1);
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [3:0] act_ct;
    logic [3:0] stop_ct;
    logic [1:0] act_wt;
    logic [1:0] stop_wt;
    logic       flash_odd;

    assign flash_odd = r_cnt[0] ^ WALK_STEADY[0];

    // Light decode of the registered phase; emergency forces walkers to red immediately
    always_comb begin
        act_ct  = 4'b0000;
        stop_ct = 4'b0000;
        act_wt  = WT_DARK;
        stop_wt = WT_DARK;
        case (r_state)
            S_GREEN:        begin act_ct = CT_GREEN;  stop_ct = CT_RED; end
            S_YEL1, S_YEL2: begin act_ct = CT_YELLOW; stop_ct = CT_RED; end
            S_LEFT:         begin act_ct = CT_LEFT;   stop_ct = CT_RED; end
            S_ALLRED:       begin act_ct = CT_RED;    stop_ct = CT_RED; end
            default:        ;
        endcase
        if (r_state != S_IDLE) begin
            act_wt  = WT_RED;
            stop_wt = WT_RED;
            if (r_state == S_GREEN && r_walk && !i_emg_req) begin
                if (r_cnt < WALK_STEADY)   stop_wt = WT_GREEN;
                else if (r_cnt < WALK_END) stop_wt = flash_odd ? WT_GREEN : WT_DARK;
            end
        end
    end

    assign o_e_ct        = r_axis ? stop_ct : act_ct;
    assign o_w_ct        = r_axis ? stop_ct : act_ct;
    assign o_s_ct        = r_axis ? act_ct  : stop_ct;
    assign o_n_ct        = r_axis ? act_ct  : stop_ct;
    assign o_e_wt        = r_axis ? stop_wt : act_wt;
    assign o_w_wt        = r_axis ? stop_wt : act_wt;
    assign o_s_wt        = r_axis ? act_wt  : stop_wt;
    assign o_n_wt        = r_axis ? act_wt  : stop_wt;
    assign o_axis        = r_axis;
    assign o_ped_pending = r_pend;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios then random traffic against a cycle-position
// model of the intersection. Honours PED_DEMAND_EN the same way the design does.
module tb_intersection_scheduler;

    localparam int TG  = 20;
    localparam int TY  = 2;
    localparam int TL  = 10;
    localparam int TA  = 2;
    localparam int TW  = 14;
    localparam int TF  = 6;
    localparam int CYC = TG + 2*TY + TL + TA;
    localparam int YEL2_AT = TG + TY + TL;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_start;
    logic       i_tick;
    logic [3:0] i_ped_req;
    logic       i_emg_req;
    logic       i_emg_axis;
    logic [3:0] o_e_ct, o_w_ct, o_s_ct, o_n_ct;
    logic [1:0] o_e_wt, o_w_wt, o_s_wt, o_n_wt;
    logic       o_axis;
    logic [3:0] o_ped_pending;
    logic [24:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: position within one axis cycle, plus axis, walk grant and pending requests
    bit         m_run;
    bit         m_axis;
    int         m_t;
    bit         m_walk;
    logic [3:0] m_pend;

    intersection_scheduler dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_tick(i_tick),
        .i_ped_req(i_ped_req), .i_emg_req(i_emg_req), .i_emg_axis(i_emg_axis),
        .o_e_ct(o_e_ct), .o_w_ct(o_w_ct), .o_s_ct(o_s_ct), .o_n_ct(o_n_ct),
        .o_e_wt(o_e_wt), .o_w_wt(o_w_wt), .o_s_wt(o_s_wt), .o_n_wt(o_n_wt),
        .o_axis(o_axis), .o_ped_pending(o_ped_pending)
    );

    assign dut_vec = {o_e_ct, o_w_ct, o_s_ct, o_n_ct, o_e_wt, o_w_wt, o_s_wt, o_n_wt, o_axis};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [24:0] expected(input logic emg);
        logic [3:0] act;
        logic [3:0] stp;
        logic [1:0] awt;
        logic [1:0] swt;
        if (!m_run) return 25'd0;
        stp = 4'b1000;
        awt = 2'b10;
        swt = 2'b10;
        if (m_t < TG)                act = 4'b0001;
        else if (m_t < TG + TY)      act = 4'b0100;
        else if (m_t < TG + TY + TL) act = 4'b0010;
        else if (m_t < YEL2_AT + TY) act = 4'b0100;
        else                         act = 4'b1000;
        if (m_t < TG && m_walk && !emg) begin
            if (m_t < TW - TF)  swt = 2'b01;
            else if (m_t < TW)  swt = (((m_t - (TW - TF)) % 2) == 1) ? 2'b01 : 2'b00;
        end
        if (!m_axis) return {act, act, stp, stp, awt, awt, swt, swt, 1'b0};
        return {stp, stp, act, act, swt, swt, awt, awt, 1'b1};
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_axis = 1'b0;
        m_t    = 0;
        m_walk = 1'b0;
        m_pend = 4'b0000;
    endtask

    task automatic model_update(input logic st, input logic tk, input logic [3:0] pd,
                                input logic em, input logic ea);
        logic [3:0] np;
        logic [3:0] mask;
        bit         enter;
        bit         nax;
        np    = m_pend | pd;
        enter = 1'b0;
        nax   = m_axis;
        if (!st) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_axis = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            enter = 1'b1;
            nax   = 1'b0;
        end else if (tk) begin
            if (em && ea != m_axis && m_t < YEL2_AT) m_t = YEL2_AT;
            else if (em && ea == m_axis && m_t < TG) m_t = m_t;
            else if (m_t == CYC - 1) begin
                enter = 1'b1;
                nax   = (em && ea == m_axis) ? m_axis : !m_axis;
            end else m_t++;
        end
        if (enter) begin
            mask = nax ? 4'b0011 : 4'b1100;
`ifdef PED_DEMAND_EN
            m_walk = |(m_pend & mask);
`else
            m_walk = 1'b1;
`endif
            if (m_walk) np = np & ~mask;
            m_axis = nax;
            m_t    = 0;
        end
        m_pend = np;
    endtask

    // One clock with the given inputs, then compare everything against the model
    task automatic step(input logic st, input logic tk, input logic [3:0] pd,
                        input logic em, input logic ea);
        i_start    = st;
        i_tick     = tk;
        i_ped_req  = pd;
        i_emg_req  = em;
        i_emg_axis = ea;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_update(st, tk, pd, em, ea);
        #1;
        check("lights", 32'(dut_vec), 32'(expected(em)));
        check("pending", 32'(o_ped_pending), 32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        logic st, tk, em, ea;
        logic [3:0] pd;

        reset_n = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        run(6);

        // Asynchronous reset in the middle of GREEN
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_lights", 32'(dut_vec), 32'd0);
        check("async_rst_pend", 32'(o_ped_pending), 32'd0);
        run(2);
        reset_n = 1'b1;
        run(1);
        check("green_entry_e", 32'(o_e_ct), 32'h1);
        check("green_entry_s", 32'(o_s_ct), 32'h8);

        n = 0;
        do begin
            run(1);
            n++;
        end while (o_e_ct === 4'b0001 && n < 40);
        check("green_len", 32'(n), 32'd20);
        run(16);
        check("axis_after_36", 32'(o_axis), 32'd1);
        run(36);
        check("axis_after_72", 32'(o_axis), 32'd0);

        // Pedestrian S request during axis-A LEFT, served at the next axis-A GREEN
        run(22);
        step(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
        check("ped_latched", 32'(o_ped_pending), 32'h4);
        run(13);
        run(35);
        check("ped_held_thru_b", 32'(o_ped_pending), 32'h4);
        run(1);
        check("ped_served", 32'(o_ped_pending), 32'h0);
        check("ped_walk_s", 32'(o_s_wt), 32'h1);

        // Emergency toward axis B at GREEN tick 5 of axis A
        run(5);
        step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
        check("emg_yel2", 32'(o_e_ct), 32'h4);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
        check("emg_n_green", 32'(o_n_ct), 32'h1);
        check("emg_e_red", 32'(o_e_ct), 32'h8);
        check("emg_walkers", 32'({o_e_wt, o_w_wt, o_s_wt, o_n_wt}), 32'hAA);

        // Drop start during axis-B LEFT, then restart
        run(22);
        step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("stop_lights", 32'(dut_vec), 32'd0);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("restart_e", 32'(o_e_ct), 32'h1);
        check("restart_axis", 32'(o_axis), 32'd0);

        // Same-clock set and clear on the pending latch at axis-A GREEN entry
        run(36);
        run(5);
        step(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
        run(29);
        step(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
        check("clear_wins", 32'(o_ped_pending), 32'h1);

        // Random traffic
        em = 1'b0;
        ea = 1'b0;
        for (int k = 0; k < 900; k++) begin
            st = ($urandom_range(0, 99) < 98);
            tk = ($urandom_range(0, 9) < 7);
            pd = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) < 3) begin
                em = ~em;
                ea = 1'($urandom);
            end
            step(st, tk, pd, em, ea);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
